signed_shift_exec: RTL and testbench

Sequential executor for ALU32 shifts given as a signed two's-complement shift amount. It decodes the amount into direction and magnitude, recovering the magnitude of negative amounts by negation. It then shifts a 32-bit operand one bit per clock under a start/busy/done handshake. It sits beside the gate-level ALU32 datapath and serves the multi-cycle shift path.

---
 rtl/signed_shift_exec.sv | 110 +++++++++++
 tb/tb_signed_shift_exec.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_shift_exec.sv
// Multi-cycle shifter for the ALU32 shift path: decodes a signed shift amount
// into direction/magnitude, then shifts the captured operand one bit per clock.
module signed_shift_exec #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dir_out,
  output logic [AMT_W-1:0] mag_out,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request pulse taken only in IDLE; busy is high in
  // SHIFT and DONE; done is a one-cycle pulse after which result is final.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_result;
  logic             r_arith;
  logic             r_dir;
  logic [AMT_W-1:0] r_mag;
  logic [AMT_W-1:0] r_cnt;

  logic             w_neg;
  logic [AMT_W-1:0] w_mag;
  logic             w_fill;

  // Negation wraps -32 onto 6'b100000, which reads as an unsigned 32.
  assign w_neg  = amount[AMT_W-1];
  assign w_mag  = w_neg ? (~amount + AMT_W'(1)) : amount;
  assign w_fill = r_arith & r_result[WIDTH-1];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (w_mag == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_arith  <= 1'b0;
      r_dir    <= 1'b0;
      r_mag    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_result <= data_in;
            r_arith  <= arith;
            r_dir    <= w_neg;
            r_mag    <= w_mag;
            r_cnt    <= w_mag;
          end
        end
        ST_SHIFT: begin
          if (r_dir) begin
            r_result <= {w_fill, r_result[WIDTH-1:1]};
          end else begin
            r_result <= {r_result[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign dir_out   = r_dir;
  assign mag_out   = r_mag;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_signed_shift_exec.sv
// Bench for signed_shift_exec: directed vector table, hand-written corner
// sequences, then random operations checked against an arithmetic model.
module tb_signed_shift_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [5:0]  amount;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        dir_out;
  logic [5:0]  mag_out;
  logic [1:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [5:0]  amt;
    logic        ar;
    logic [31:0] exp_res;
    logic        exp_dir;
    logic [5:0]  exp_mag;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  signed_shift_exec #(.WIDTH(32), .AMT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .arith     (arith),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dir_out   (dir_out),
    .mag_out   (mag_out),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: shift amount read as a signed integer, shift done with
  // plain operators on a 64-bit pre-extended operand.
  function automatic void model(input logic [31:0] d, input logic [5:0] a, input logic ar,
                                output logic [31:0] r, output logic dr, output logic [5:0] m);
    int          sa;
    logic [63:0] x;
    sa = $signed(a);
    if (sa >= 0) begin
      dr = 1'b0;
      m  = 6'(sa);
      r  = d << sa;
    end else begin
      dr = 1'b1;
      m  = 6'(-sa);
      x  = ar ? {{32{d[31]}}, d} : {32'b0, d};
      x  = x >> (-sa);
      r  = x[31:0];
    end
  endfunction

  // driver: called at a negedge; returns just after the accepting posedge
  task automatic start_op(input logic [31:0] d, input logic [5:0] a, input logic ar);
    data_in = d;
    amount  = a;
    arith   = ar;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge; n0 already elapsed.
  task automatic wait_done(input int n0, input int max_cyc, output int lat, output bit busy_ok);
    int n;
    n       = n0;
    lat     = -1;
    busy_ok = 1'b1;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_op(input string name, input int n0, input logic [31:0] exp_res,
                           input logic exp_dir, input logic [5:0] exp_mag, input int exp_lat);
    int lat;
    bit busy_ok;
    wait_done(n0, 45, lat, busy_ok);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
    check({name, " result"}, result, exp_res);
    check({name, " dir"}, {31'b0, dir_out}, {31'b0, exp_dir});
    check({name, " mag"}, {26'b0, mag_out}, {26'b0, exp_mag});
    @(negedge clk);
    check({name, " done_width"}, {30'b0, busy, done}, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [31:0] d, input logic [5:0] a, input logic ar,
                       input logic [31:0] exp_res, input logic exp_dir, input logic [5:0] exp_mag,
                       input int exp_lat);
    start_op(d, a, ar);
    finish_op(name, 0, exp_res, exp_dir, exp_mag, exp_lat);
  endtask

  initial begin
    int          lat;
    bit          busy_ok;
    bit          no_done;
    logic [31:0] r;
    logic        dr;
    logic [5:0]  m;

    vecs[0]  = '{32'h0000_00F1, 6'd4,      1'b0, 32'h0000_0F10, 1'b0, 6'd4,  5};
    vecs[1]  = '{32'h8000_00F0, 6'b111100, 1'b1, 32'hF800_000F, 1'b1, 6'd4,  5};
    vecs[2]  = '{32'h8000_00F0, 6'b111100, 1'b0, 32'h0800_000F, 1'b1, 6'd4,  5};
    vecs[3]  = '{32'h8000_0001, 6'b100000, 1'b1, 32'hFFFF_FFFF, 1'b1, 6'd32, 33};
    vecs[4]  = '{32'h8000_0001, 6'b100000, 1'b0, 32'h0000_0000, 1'b1, 6'd32, 33};
    vecs[5]  = '{32'h1234_5678, 6'd0,      1'b0, 32'h1234_5678, 1'b0, 6'd0,  1};
    vecs[6]  = '{32'h0000_0001, 6'd31,     1'b0, 32'h8000_0000, 1'b0, 6'd31, 32};
    vecs[7]  = '{32'h1234_5678, 6'd0,      1'b1, 32'h1234_5678, 1'b0, 6'd0,  1};
    vecs[8]  = '{32'hFFFF_FFFF, 6'b111111, 1'b1, 32'hFFFF_FFFF, 1'b1, 6'd1,  2};
    vecs[9]  = '{32'h8000_0000, 6'b111111, 1'b0, 32'h4000_0000, 1'b1, 6'd1,  2};
    vecs[10] = '{32'h8000_0001, 6'd1,      1'b1, 32'h0000_0002, 1'b0, 6'd1,  2};

    rst     = 1'b1;
    start   = 1'b0;
    data_in = 32'hDEAD_BEEF;
    amount  = 6'd5;
    arith   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset dir", {31'b0, dir_out}, 32'd0);
    check("reset mag", {26'b0, mag_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].ar,
            vecs[i].exp_res, vecs[i].exp_dir, vecs[i].exp_mag, vecs[i].exp_lat);
    end

    // start pulsed mid-operation with different operands is ignored
    start_op(32'h0000_0003, 6'd10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    data_in = 32'hFFFF_FFFF;
    amount  = 6'b111011;
    arith   = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    finish_op("busy_start", 3, 32'h0000_0C00, 1'b0, 6'd10, 11);

    // reset mid-shift clears everything and no done follows
    start_op(32'hF000_0000, 6'b110110, 1'b1);
    for (int n = 1; n <= 5; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst dir", {31'b0, dir_out}, 32'd0);
    check("midrst mag", {26'b0, mag_out}, 32'd0);
    no_done = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("midrst quiet", {31'b0, no_done}, 32'd1);

    // start held across DONE (ignored) and the following IDLE (accepted)
    start_op(32'h0000_0001, 6'd2, 1'b0);
    wait_done(0, 45, lat, busy_ok);
    check("b2b op1 latency", 32'(lat), 32'd3);
    check("b2b op1 result", result, 32'h0000_0004);
    data_in = 32'h0000_0080;
    amount  = 6'b111101;
    arith   = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    check("b2b done_cycle_start", {30'b0, busy, done}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("b2b op2", 0, 32'h0000_0010, 1'b1, 6'd3, 4);

    // start only during DONE: ignored, no extra done, result held
    start_op(32'h0000_0005, 6'd1, 1'b0);
    wait_done(0, 45, lat, busy_ok);
    check("done_start latency", 32'(lat), 32'd2);
    data_in = 32'hAAAA_AAAA;
    amount  = 6'd3;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    no_done = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("done_start ignored", {31'b0, no_done}, 32'd1);
    check("done_start held", result, 32'h0000_000A);

    // random operations against the model through the expected queue
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic [5:0]  a;
      logic        ar;
      d  = $urandom;
      a  = 6'($urandom_range(0, 63));
      ar = 1'($urandom_range(0, 1));
      model(d, a, ar, r, dr, m);
      exp_q.push_back(r);
      do_op($sformatf("rand%0d", i), d, a, ar, exp_q.pop_front(), dr, m, int'(m) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
